// File: rtl/log_scale_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : log_mul_pkg
//  Purpose  : Shared types, widths and helpers for the log-domain fp16 multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package log_mul_pkg;

    localparam int FLOAT_LEN = 16;
    localparam int EXP_LEN   = 5;
    localparam int MANT_LEN  = 10;
    localparam int LUT_SIZE  = 128;
    localparam int LUT_AW    = 7;
    localparam int BIAS      = 15;
    localparam int INT_LEN   = 7;
    localparam int FIX_LEN   = INT_LEN + MANT_LEN;
    localparam int ESUM_LEN  = 9;

    typedef struct packed {
        logic                sign;
        logic [EXP_LEN-1:0]  exp;
        logic [MANT_LEN-1:0] mant;
    } fp16_t;

    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_ZERO = 2'd1,
        SPC_INF  = 2'd2,
        SPC_NAN  = 2'd3
    } spc_e;

    localparam logic [EXP_LEN-1:0]  c_exp_inf   = 5'h1f;
    localparam logic [MANT_LEN-1:0] c_qnan_mant = 10'h200;

    function automatic logic is_special(input fp16_t x);
        return (x.exp == '0) || (x.exp == c_exp_inf);
    endfunction

    // Round a 10-bit fraction to a 7-bit LUT index; bit 7 is the carry-out.
    function automatic logic [LUT_AW:0] round_idx(input logic [MANT_LEN-1:0] f);
        return {1'b0, f[MANT_LEN-1:3]} + {{LUT_AW{1'b0}}, f[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/log_scale_mul_lut_ram.sv
`default_nettype none
// ============================================================================
//  Module   : log_lut_ram
//  Purpose  : Serially loaded register-file LUT, sync write / async multi-port read.
//  Revision : 1.0 - initial release
// ============================================================================
module log_lut_ram #(
    parameter int W        = 10,
    parameter int RD_PORTS = 1,
    parameter int DEPTH    = 128,
    parameter int AW       = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [W-1:0]                  i_wr_data,
    input  logic [RD_PORTS-1:0][AW-1:0]   i_rd_addr,
    output logic [RD_PORTS-1:0][W-1:0]    o_rd_data
);

    logic [W-1:0]  r_mem_q [DEPTH];
    logic [AW-1:0] r_wr_addr_q;
    logic [AW-1:0] w_wr_addr_d;

    always_comb begin
        w_wr_addr_d = r_wr_addr_q;
        if (i_wr_en) begin
            w_wr_addr_d = r_wr_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr_q <= '0;
        end else begin
            r_wr_addr_q <= w_wr_addr_d;
        end
    end

    // Contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && i_wr_en) begin
            r_mem_q[r_wr_addr_q] <= i_wr_data;
        end
    end

    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            o_rd_data[p] = r_mem_q[i_rd_addr[p]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/log_scale_mul.sv
`default_nettype none
// ============================================================================
//  Module   : log_scale_mul
//  Purpose  : Two-stage fp16 multiplier: log2 add in stage 1, exp2 back in stage 2.
//  Revision : 1.0 - initial release
// ============================================================================
module log_scale_mul
    import log_mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLOAT_LEN-1:0] a,
    input  logic [FLOAT_LEN-1:0] b,
    input  logic                 lut_wr_en,
    input  logic [MANT_LEN-1:0]  log2_lut_data_in,
    input  logic [FLOAT_LEN-1:0] exp2_lut_data_in,
    output logic [FLOAT_LEN-1:0] result
);

    fp16_t                       w_a;
    fp16_t                       w_b;
    logic [LUT_AW:0]             w_a_idx_rnd;
    logic [LUT_AW:0]             w_b_idx_rnd;
    logic [1:0][LUT_AW-1:0]      w_log_addr;
    logic [1:0][MANT_LEN-1:0]    w_log_frac;
    logic [INT_LEN-1:0]          w_a_int;
    logic [INT_LEN-1:0]          w_b_int;
    logic                        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    logic                        w_sign_d,  r_sign_q;
    logic [FIX_LEN-1:0]          w_sum_d,   r_sum_q;
    spc_e                        w_kind_d,  r_kind_q;

    logic [LUT_AW:0]             w_fidx_rnd;
    logic [FLOAT_LEN-1:0]        w_e2;
    logic [ESUM_LEN-1:0]         w_exp_sum;
    fp16_t                       w_result_d;
    logic [FLOAT_LEN-1:0]        r_result_q;
    logic                        w_unused_e2_sign;

    assign w_a = a;
    assign w_b = b;

    // ---------------- stage 1: log2 of each operand and their sum ----------------
    assign w_a_idx_rnd = round_idx(w_a.mant);
    assign w_b_idx_rnd = round_idx(w_b.mant);
    assign w_log_addr  = {w_b_idx_rnd[LUT_AW-1:0], w_a_idx_rnd[LUT_AW-1:0]};

    assign w_a_int = {2'b00, w_a.exp} - INT_LEN'(BIAS) + INT_LEN'(w_a_idx_rnd[LUT_AW]);
    assign w_b_int = {2'b00, w_b.exp} - INT_LEN'(BIAS) + INT_LEN'(w_b_idx_rnd[LUT_AW]);

    // Two's-complement {int, frac} words add directly; frac carry lands in int.
    assign w_sum_d  = {w_a_int, w_log_frac[0]} + {w_b_int, w_log_frac[1]};
    assign w_sign_d = w_a.sign ^ w_b.sign;

    assign w_a_nan  = (w_a.exp == c_exp_inf) && (w_a.mant != '0);
    assign w_b_nan  = (w_b.exp == c_exp_inf) && (w_b.mant != '0);
    assign w_a_inf  = (w_a.exp == c_exp_inf) && (w_a.mant == '0);
    assign w_b_inf  = (w_b.exp == c_exp_inf) && (w_b.mant == '0);
    assign w_a_zero = (w_a.exp == '0);
    assign w_b_zero = (w_b.exp == '0);

    always_comb begin
        w_kind_d = SPC_NONE;
        if (is_special(w_a) || is_special(w_b)) begin
            if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
                w_kind_d = SPC_NAN;
            end else if (w_a_inf || w_b_inf) begin
                w_kind_d = SPC_INF;
            end else begin
                w_kind_d = SPC_ZERO;
            end
        end
    end

    log_lut_ram #(
        .W        (MANT_LEN),
        .RD_PORTS (2),
        .DEPTH    (LUT_SIZE),
        .AW       (LUT_AW)
    ) u_log2_lut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (lut_wr_en),
        .i_wr_data (log2_lut_data_in),
        .i_rd_addr (w_log_addr),
        .o_rd_data (w_log_frac)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign_q <= 1'b0;
            r_sum_q  <= '0;
            r_kind_q <= SPC_NONE;
        end else begin
            r_sign_q <= w_sign_d;
            r_sum_q  <= w_sum_d;
            r_kind_q <= w_kind_d;
        end
    end

    // ---------------- stage 2: exp2 of the sum back to fp16 ----------------
    assign w_fidx_rnd = round_idx(r_sum_q[MANT_LEN-1:0]);

    log_lut_ram #(
        .W        (FLOAT_LEN),
        .RD_PORTS (1),
        .DEPTH    (LUT_SIZE),
        .AW       (LUT_AW)
    ) u_exp2_lut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (lut_wr_en),
        .i_wr_data (exp2_lut_data_in),
        .i_rd_addr (w_fidx_rnd[LUT_AW-1:0]),
        .o_rd_data (w_e2)
    );

    assign w_unused_e2_sign = w_e2[FLOAT_LEN-1];

    assign w_exp_sum = {4'd0, w_e2[FLOAT_LEN-2:MANT_LEN]}
                     + {{2{r_sum_q[FIX_LEN-1]}}, r_sum_q[FIX_LEN-1:MANT_LEN]}
                     + ESUM_LEN'(w_fidx_rnd[LUT_AW]);

    always_comb begin
        w_result_d.sign = r_sign_q;
        w_result_d.exp  = w_exp_sum[EXP_LEN-1:0];
        w_result_d.mant = w_e2[MANT_LEN-1:0];
        case (r_kind_q)
            SPC_NAN: begin
                w_result_d.exp  = c_exp_inf;
                w_result_d.mant = c_qnan_mant;
            end
            SPC_INF: begin
                w_result_d.exp  = c_exp_inf;
                w_result_d.mant = '0;
            end
            SPC_ZERO: begin
                w_result_d.exp  = '0;
                w_result_d.mant = '0;
            end
            default: begin
                // Negative or zero biased exponent underflows; no subnormal outputs.
                if (w_exp_sum[ESUM_LEN-1] || (w_exp_sum == '0)) begin
                    w_result_d.exp  = '0;
                    w_result_d.mant = '0;
                end else if (w_exp_sum >= ESUM_LEN'(31)) begin
                    w_result_d.exp  = c_exp_inf;
                    w_result_d.mant = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_q <= '0;
        end else begin
            r_result_q <= w_result_d;
        end
    end

    assign result = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_log_scale_mul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_log_scale_mul
//  Purpose  : Self-checking bench for log_scale_mul against a real-valued product model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_log_scale_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        lut_wr_en;
    logic [9:0]  log2_lut_data_in;
    logic [15:0] exp2_lut_data_in;
    logic [15:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  log_tab [128];
    logic [15:0] exp_tab [128];

    log_scale_mul u_dut (
        .clk              (clk),
        .rst              (rst),
        .a                (a),
        .b                (b),
        .lut_wr_en        (lut_wr_en),
        .log2_lut_data_in (log2_lut_data_in),
        .exp2_lut_data_in (exp2_lut_data_in),
        .result           (result)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp16_to_real(input logic [15:0] x);
        real mag;
        int  e;
        e = int'(x[14:10]);
        if (e == 0) mag = real'(x[9:0]) * pow2(-24);
        else        mag = (1.0 + real'(x[9:0]) / 1024.0) * pow2(e - 15);
        return x[15] ? -mag : mag;
    endfunction

    // Random normal operand with 2^-6 <= |x| < 10.
    function automatic logic [15:0] rand_op();
        logic [4:0] e;
        logic [9:0] m;
        e = 5'($urandom_range(18, 9));
        m = (e == 5'd18) ? 10'($urandom_range(255, 0)) : 10'($urandom_range(1023, 0));
        return {1'($urandom_range(1, 0)), e, m};
    endfunction

    task automatic load_luts(input bit corrupt, input int count, input int gap_at);
        for (int i = 0; i < count; i++) begin
            if (i == gap_at) begin
                lut_wr_en = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            lut_wr_en        = 1'b1;
            log2_lut_data_in = corrupt ? 10'($urandom) : log_tab[i % 128];
            exp2_lut_data_in = corrupt ? 16'($urandom) : exp_tab[i % 128];
            @(posedge clk);
            #1;
        end
        lut_wr_en = 1'b0;
    endtask

    task automatic mul_once(input logic [15:0] ia, input logic [15:0] ib, output logic [15:0] r);
        a = ia;
        b = ib;
        repeat (2) @(posedge clk);
        #1;
        r = result;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        lut_wr_en = 1'b0;
        a         = 16'h3C00;
        b         = 16'h3C00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected %h", result, 16'h0000);
        end
        rst = 1'b0;
    endtask

    task automatic test_exact();
        logic [15:0] r;
        mul_once(16'h3C00, 16'h3C00, r);
        n_checks++;
        if (r !== 16'h3C00) begin
            n_fail++;
            $display("FAIL one_times_one: got %h expected %h", r, 16'h3C00);
        end
        mul_once(16'hC000, 16'h4400, r);
        n_checks++;
        if (r !== 16'hC800) begin
            n_fail++;
            $display("FAIL neg2_times_4: got %h expected %h", r, 16'hC800);
        end
        mul_once(16'h4000, 16'h4200, r);
        n_checks++;
        if ($isunknown(r) || r < 16'h45F4 || r > 16'h460C) begin
            n_fail++;
            $display("FAIL two_times_three: got %h expected 4600+-000c", r);
        end
    endtask

    task automatic test_back_to_back(input int n_ops);
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic [15:0] ea, eb;
        real         p, g, err, ap;
        for (int n = 0; n < n_ops + 2; n++) begin
            if (n >= 2) begin
                ea  = qa.pop_front();
                eb  = qb.pop_front();
                p   = fp16_to_real(ea) * fp16_to_real(eb);
                ap  = (p < 0.0) ? -p : p;
                n_checks++;
                if ($isunknown(result)) begin
                    n_fail++;
                    $display("FAIL stream_product: a=%h b=%h got %h expected ~%f", ea, eb, result, p);
                end else begin
                    g   = fp16_to_real(result);
                    err = (g > p) ? (g - p) : (p - g);
                    if (result[15] != (ea[15] ^ eb[15]) || result[14:10] == 5'h1f
                        || result[14:10] == 5'h00 || err > 0.019 * ap) begin
                        n_fail++;
                        $display("FAIL stream_product: a=%h b=%h got %h (%f) expected ~%f",
                                 ea, eb, result, g, p);
                    end
                end
            end
            if (n < n_ops) begin
                a = rand_op();
                b = rand_op();
                qa.push_back(a);
                qb.push_back(b);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_subnormal();
        logic [15:0] ta [3] = '{16'h0000, 16'h8000, 16'h0001};
        logic [15:0] tb [3] = '{16'h4500, 16'h4500, 16'h3C00};
        logic [15:0] te [3] = '{16'h0000, 16'h8000, 16'h0000};
        logic [15:0] r;
        for (int i = 0; i < 3; i++) begin
            mul_once(ta[i], tb[i], r);
            n_checks++;
            if (r !== te[i]) begin
                n_fail++;
                $display("FAIL zero_case%0d: a=%h b=%h got %h expected %h", i, ta[i], tb[i], r, te[i]);
            end
        end
    endtask

    task automatic test_overflow_special();
        logic [15:0] ta [6] = '{16'h7BFF, 16'h0400, 16'h7C00, 16'hFC00, 16'h7C01, 16'h3C00};
        logic [15:0] tb [6] = '{16'h7BFF, 16'h0400, 16'h0000, 16'h4000, 16'h3C00, 16'hFE00};
        logic [15:0] te [6] = '{16'h7C00, 16'h0000, 16'h7E00, 16'hFC00, 16'h7E00, 16'hFE00};
        logic [15:0] r;
        for (int i = 0; i < 6; i++) begin
            mul_once(ta[i], tb[i], r);
            n_checks++;
            if (r !== te[i]) begin
                n_fail++;
                $display("FAIL special_case%0d: a=%h b=%h got %h expected %h", i, ta[i], tb[i], r, te[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            a = 16'h4000 | 16'($urandom_range(1023, 1));
            b = 16'h4400;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_midstream: got %h expected %h", result, 16'h0000);
        end
        rst = 1'b0;
        mul_once(16'hC000, 16'h4400, r);
        n_checks++;
        if (r !== 16'hC800) begin
            n_fail++;
            $display("FAIL after_stream_reset: got %h expected %h", r, 16'hC800);
        end
    endtask

    task automatic test_reset_midload();
        logic [15:0] r;
        a = 16'h4200;
        b = 16'h4500;
        load_luts(1'b1, 50, -1);
        lut_wr_en = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_midload: got %h expected %h", result, 16'h0000);
        end
        rst       = 1'b0;
        lut_wr_en = 1'b0;
        load_luts(1'b0, 128, -1);
        mul_once(16'h3C00, 16'h3C00, r);
        n_checks++;
        if (r !== 16'h3C00) begin
            n_fail++;
            $display("FAIL reload_one_times_one: got %h expected %h", r, 16'h3C00);
        end
        test_back_to_back(100);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            log_tab[i] = 10'(int'($ln(1.0 + i / 128.0) / $ln(2.0) * 1024.0));
            exp_tab[i] = {1'b0, 5'd15, 10'(int'(($exp(i / 128.0 * $ln(2.0)) - 1.0) * 1024.0))};
        end
        rst              = 1'b1;
        lut_wr_en        = 1'b0;
        log2_lut_data_in = '0;
        exp2_lut_data_in = '0;
        a                = '0;
        b                = '0;
        #1;
        test_reset();
        load_luts(1'b0, 128, 64);
        test_exact();
        test_back_to_back(1000);
        test_zero_subnormal();
        test_overflow_special();
        test_reset_midstream();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
